// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART CSR scheduler.
package uart_sched_pkg;

    // Scheduler states; INIT is the reset state and writes the baud divisor.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        TX_WR,
        TX_WAIT,
        RX_RD,
        RX_CAP
    } sched_state_t;

    // Register offsets inside the uart CSR page.
    localparam logic [1:0] CSR_RXTX = 2'b00;
    localparam logic [1:0] CSR_DIV  = 2'b01;
    localparam logic [1:0] CSR_THRU = 2'b10;

    // Build a full CSR address from the page number and register offset.
    function automatic logic [13:0] csr_addr_of(input logic [3:0] page,
                                                input logic [1:0] offset);
        return {page, 8'd0, offset};
    endfunction

endpackage

// File: rtl/uart_csr_sched_if.sv
// Requester, receive and uart CSR signals of the scheduler, bundled.
interface uart_csr_sched_if;

    logic        req0_valid;
    logic        req1_valid;
    logic [7:0]  req0_data;
    logic [7:0]  req1_data;
    logic        req0_ready;
    logic        req1_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        rx_irq;
    logic        tx_irq;
    logic        busy;
    logic        tx_timeout;
    logic        rx_overrun;

    // Scheduler side.
    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        input  csr_do, rx_irq, tx_irq,
        output req0_ready, req1_ready, rx_valid, rx_data,
        output csr_a, csr_we, csr_di, busy, tx_timeout, rx_overrun
    );

    // Requesters and uart side.
    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        output csr_do, rx_irq, tx_irq,
        input  req0_ready, req1_ready, rx_valid, rx_data,
        input  csr_a, csr_we, csr_di, busy, tx_timeout, rx_overrun
    );

endinterface

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin arbiter; requester 0 wins the first contested grant.
module uart_rr_arb2 (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic advance,
    output logic gnt_valid,
    output logic gnt_sel
);

    logic last_grant;

    // Pick the single valid requester, or the one not granted last time.
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        gnt_sel   = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_grant;
        end else if (req1_valid) begin
            gnt_sel = 1'b1;
        end
    end

    // Remember who was served when a grant is actually taken.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= gnt_sel;
        end
    end

endmodule

// File: rtl/uart_csr_sched.sv
// Schedules two TX requesters and RX draining onto a single uart CSR port.
module uart_csr_sched #(
    parameter logic [3:0]  csr_addr     = 4'h0,
    parameter logic [15:0] init_divisor = 16'd27,
    parameter logic [15:0] tx_timeout   = 16'd65535
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    uart_csr_sched_if.slave  bus
);

    import uart_sched_pkg::*;

    sched_state_t state;
    sched_state_t next_state;

    logic        rx_pend;
    logic        tx_out;
    logic        tx_done_pend;
    logic [15:0] wait_cnt;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        tx_timeout_q;
    logic        rx_overrun_q;

    logic [13:0] csr_a_d;
    logic        csr_we_d;
    logic [31:0] csr_di_d;

    logic gnt_valid;
    logic gnt_sel;
    logic grant_fire;
    logic tx_wait_live;
    logic tx_done_now;
    logic timeout_now;
    logic rx_rd_entry;
    logic unused_csr_do;

    assign unused_csr_do = ^bus.csr_do[31:8];

    uart_rr_arb2 u_arb (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req0_valid (bus.req0_valid),
        .req1_valid (bus.req1_valid),
        .advance    (grant_fire),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    // A pending RX byte always pre-empts granting and TX completion.
    assign grant_fire   = (state == IDLE) && !rx_pend && gnt_valid;
    assign tx_wait_live = (state == TX_WAIT) && !rx_pend;
    assign tx_done_now  = tx_wait_live && (tx_done_pend || bus.tx_irq);
    assign timeout_now  = tx_wait_live && !(tx_done_pend || bus.tx_irq)
                          && (wait_cnt == tx_timeout);
    assign rx_rd_entry  = (next_state == RX_RD) && (state != RX_RD);

    // Next-state selection and the CSR access each state performs.
    always_comb begin
        next_state = state;
        csr_a_d    = '0;
        csr_we_d   = 1'b0;
        csr_di_d   = '0;
        case (state)
            INIT: begin
                csr_a_d    = csr_addr_of(csr_addr, CSR_DIV);
                csr_we_d   = 1'b1;
                csr_di_d   = {16'd0, init_divisor};
                next_state = IDLE;
            end
            IDLE: begin
                if (rx_pend) begin
                    next_state = RX_RD;
                end else if (gnt_valid) begin
                    next_state = TX_WR;
                end
            end
            TX_WR: begin
                csr_a_d    = csr_addr_of(csr_addr, CSR_RXTX);
                csr_we_d   = 1'b1;
                csr_di_d   = {24'd0, tx_byte};
                next_state = TX_WAIT;
            end
            TX_WAIT: begin
                if (rx_pend) begin
                    next_state = RX_RD;
                end else if (tx_done_now || timeout_now) begin
                    next_state = IDLE;
                end
            end
            RX_RD: begin
                csr_a_d    = csr_addr_of(csr_addr, CSR_RXTX);
                next_state = RX_CAP;
            end
            RX_CAP: begin
                next_state = tx_out ? TX_WAIT : IDLE;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // CSR outputs are forced low while reset is held, even though INIT is active.
    assign bus.csr_a      = sys_rst_n ? csr_a_d  : '0;
    assign bus.csr_we     = sys_rst_n & csr_we_d;
    assign bus.csr_di     = sys_rst_n ? csr_di_d : '0;
    assign bus.req0_ready = grant_fire && !gnt_sel;
    assign bus.req1_ready = grant_fire && gnt_sel;
    assign bus.busy       = (state != IDLE);
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.tx_timeout = tx_timeout_q;
    assign bus.rx_overrun = rx_overrun_q;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // RX bookkeeping: a new irq re-arms the pending flag even on RX_RD entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_pend      <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            rx_pend      <= bus.rx_irq | (rx_pend & ~rx_rd_entry);
            rx_overrun_q <= bus.rx_irq & rx_pend;
            rx_valid_q   <= (state == RX_CAP);
            if (state == RX_CAP) begin
                rx_data_q <= bus.csr_do[7:0];
            end
        end
    end

    // TX bookkeeping: an early tx_irq is parked until TX_WAIT can consume it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_out       <= 1'b0;
            tx_done_pend <= 1'b0;
            tx_timeout_q <= 1'b0;
            tx_byte      <= '0;
        end else begin
            tx_timeout_q <= timeout_now;
            if (grant_fire) begin
                tx_byte <= gnt_sel ? bus.req1_data : bus.req0_data;
            end
            if (state == TX_WR) begin
                tx_out <= 1'b1;
            end else if (tx_done_now || timeout_now) begin
                tx_out <= 1'b0;
            end
            if (tx_done_now) begin
                tx_done_pend <= 1'b0;
            end else if (bus.tx_irq && tx_out && !tx_wait_live) begin
                tx_done_pend <= 1'b1;
            end
        end
    end

    // Saturating wait counter; it only moves while genuinely waiting in TX_WAIT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if (state == TX_WR) begin
            wait_cnt <= '0;
        end else if (tx_wait_live && !tx_done_now && !timeout_now
                     && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_csr_sched.sv
// Self-checking bench for uart_csr_sched: table of TX transactions plus
// hand-written RX, overrun, reset and timeout sequences.
module tb_uart_csr_sched;

    logic sys_clk;
    logic sys_rst_n;

    int checks;
    int errors;

    uart_csr_sched_if b1();
    uart_csr_sched_if b2();

    // Main instance with default parameters.
    uart_csr_sched dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (b1.slave)
    );

    // Second instance with a short timeout and a non-zero CSR page.
    uart_csr_sched #(
        .csr_addr     (4'hA),
        .init_divisor (16'd13),
        .tx_timeout   (16'd10)
    ) dut_to (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (b2.slave)
    );

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         irq_delay;
        logic       exp_r0;
        logic       exp_r1;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[9];

    // Free-running clock, 10 time units per period.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Hard stop if the bench ever hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One full TX transaction on the main instance, from IDLE back to IDLE.
    task automatic apply_stimulus(input int idx, input vec_t v);
        @(negedge sys_clk);
        b1.req0_valid = v.v0;
        b1.req1_valid = v.v1;
        b1.req0_data  = v.d0;
        b1.req1_data  = v.d1;
        #1;
        check_output($sformatf("vec%0d busy_idle", idx), b1.busy, 0);
        check_output($sformatf("vec%0d ready0", idx), b1.req0_ready, v.exp_r0);
        check_output($sformatf("vec%0d ready1", idx), b1.req1_ready, v.exp_r1);
        tick();
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        check_output($sformatf("vec%0d csr_we", idx), b1.csr_we, 1);
        check_output($sformatf("vec%0d csr_a", idx), b1.csr_a, 14'h000);
        check_output($sformatf("vec%0d csr_di", idx), b1.csr_di, {24'd0, v.exp_byte});
        repeat (v.irq_delay) @(posedge sys_clk);
        #1;
        check_output($sformatf("vec%0d busy_wait", idx), b1.busy, 1);
        b1.tx_irq = 1'b1;
        tick();
        b1.tx_irq = 1'b0;
        check_output($sformatf("vec%0d busy_done", idx), b1.busy, 0);
        check_output($sformatf("vec%0d no_timeout", idx), b1.tx_timeout, 0);
    endtask

    initial begin
        int n;
        int ovr_cnt;
        int rxv_cnt;

        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 20, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 20, 1'b0, 1'b1, 8'h3C};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 20, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 20, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 8'h11, 8'hEE, 3,  1'b1, 1'b0, 8'h11};
        vecs[5] = '{1'b1, 1'b0, 8'h22, 8'hEE, 3,  1'b1, 1'b0, 8'h22};
        vecs[6] = '{1'b0, 1'b1, 8'hEE, 8'h33, 3,  1'b0, 1'b1, 8'h33};
        vecs[7] = '{1'b0, 1'b1, 8'hEE, 8'h44, 3,  1'b0, 1'b1, 8'h44};
        vecs[8] = '{1'b1, 1'b1, 8'h55, 8'h66, 3,  1'b1, 1'b0, 8'h55};

        sys_rst_n     = 1'b0;
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        b1.req0_data  = 8'h00;
        b1.req1_data  = 8'h00;
        b1.csr_do     = 32'hFF;
        b1.rx_irq     = 1'b0;
        b1.tx_irq     = 1'b0;
        b2.req0_valid = 1'b0;
        b2.req1_valid = 1'b0;
        b2.req0_data  = 8'h00;
        b2.req1_data  = 8'h00;
        b2.csr_do     = 32'hFF;
        b2.rx_irq     = 1'b0;
        b2.tx_irq     = 1'b0;

        // Values held while reset is asserted.
        repeat (3) @(posedge sys_clk);
        #1;
        b1.req0_valid = 1'b1;
        #1;
        check_output("rst busy", b1.busy, 1);
        check_output("rst csr_we", b1.csr_we, 0);
        check_output("rst csr_a", b1.csr_a, 0);
        check_output("rst csr_di", b1.csr_di, 0);
        check_output("rst rx_valid", b1.rx_valid, 0);
        check_output("rst ready0", b1.req0_ready, 0);
        b1.req0_valid = 1'b0;

        // Single divisor write right after release, then idle.
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        check_output("init csr_we", b1.csr_we, 1);
        check_output("init csr_a", b1.csr_a, 14'h001);
        check_output("init csr_di", b1.csr_di, 32'd27);
        check_output("init busy", b1.busy, 1);
        check_output("init2 csr_a", b2.csr_a, 14'h2801);
        check_output("init2 csr_di", b2.csr_di, 32'd13);
        tick();
        check_output("post_init csr_we", b1.csr_we, 0);
        check_output("post_init csr_a", b1.csr_a, 0);
        check_output("post_init busy", b1.busy, 0);
        check_output("post_init2 busy", b2.busy, 0);

        // Table of TX transactions with round-robin and single-requester grants.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // RX drain from IDLE: irq sampled on edge 1, RX_RD after edge 2,
        // RX_CAP after edge 3 (csr_do valid then), rx_valid after edge 4.
        b1.rx_irq = 1'b1;
        tick();
        b1.rx_irq = 1'b0;
        b1.req0_valid = 1'b1;
        b1.req0_data  = 8'h99;
        #1;
        check_output("rx pend blocks ready0", b1.req0_ready, 0);
        check_output("rx pend idle", b1.busy, 0);
        b1.req0_valid = 1'b0;
        tick();
        check_output("rx_rd busy", b1.busy, 1);
        check_output("rx_rd csr_a", b1.csr_a, 14'h000);
        check_output("rx_rd csr_we", b1.csr_we, 0);
        check_output("rx_rd rx_valid", b1.rx_valid, 0);
        tick();
        b1.csr_do = 32'h5A;
        check_output("rx_cap rx_valid", b1.rx_valid, 0);
        tick();
        b1.csr_do = 32'hFF;
        check_output("rx rx_valid", b1.rx_valid, 1);
        check_output("rx rx_data", b1.rx_data, 8'h5A);
        check_output("rx back idle", b1.busy, 0);
        tick();
        check_output("rx pulse end", b1.rx_valid, 0);

        // RX interleaved with a TX wait; tx_irq arrives during RX_CAP.
        @(negedge sys_clk);
        b1.req0_valid = 1'b1;
        b1.req0_data  = 8'h77;
        #1;
        check_output("mix ready0", b1.req0_ready, 1);
        tick();
        b1.req0_valid = 1'b0;
        check_output("mix csr_di", b1.csr_di, 32'h77);
        tick();
        tick();
        tick();
        b1.rx_irq = 1'b1;
        tick();
        b1.rx_irq = 1'b0;
        tick();
        check_output("mix rx_rd csr_we", b1.csr_we, 0);
        check_output("mix rx_rd busy", b1.busy, 1);
        tick();
        b1.tx_irq = 1'b1;
        b1.csr_do = 32'h99;
        tick();
        b1.tx_irq = 1'b0;
        b1.csr_do = 32'hFF;
        check_output("mix rx_valid", b1.rx_valid, 1);
        check_output("mix rx_data", b1.rx_data, 8'h99);
        check_output("mix back to wait", b1.busy, 1);
        tick();
        check_output("mix idle", b1.busy, 0);
        check_output("mix no timeout", b1.tx_timeout, 0);

        // Two rx_irq pulses back to back: one overrun, two reads.
        b1.rx_irq = 1'b1;
        tick();
        check_output("ovr first none", b1.rx_overrun, 0);
        tick();
        b1.rx_irq = 1'b0;
        check_output("ovr pulse", b1.rx_overrun, 1);
        ovr_cnt = 1;
        rxv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (b1.rx_overrun) ovr_cnt++;
            if (b1.rx_valid) rxv_cnt++;
        end
        check_output("ovr count", ovr_cnt, 1);
        check_output("ovr rx reads", rxv_cnt, 2);
        check_output("ovr idle", b1.busy, 0);

        // Reset in the middle of TX_WAIT, then divisor rewrite and clean state.
        @(negedge sys_clk);
        b1.req0_valid = 1'b1;
        b1.req0_data  = 8'hC3;
        #1;
        check_output("rst_tx ready0", b1.req0_ready, 1);
        tick();
        b1.req0_valid = 1'b0;
        check_output("rst_tx csr_di", b1.csr_di, 32'hC3);
        repeat (5) tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_output("rst_tx busy", b1.busy, 1);
        check_output("rst_tx csr_we", b1.csr_we, 0);
        check_output("rst_tx csr_di0", b1.csr_di, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        check_output("rst_tx init we", b1.csr_we, 1);
        check_output("rst_tx init a", b1.csr_a, 14'h001);
        check_output("rst_tx init di", b1.csr_di, 32'd27);
        tick();
        check_output("rst_tx idle", b1.busy, 0);
        b1.tx_irq = 1'b1;
        tick();
        b1.tx_irq = 1'b0;
        @(negedge sys_clk);
        b1.req0_valid = 1'b1;
        b1.req1_valid = 1'b1;
        b1.req0_data  = 8'h10;
        b1.req1_data  = 8'h20;
        #1;
        check_output("rst_tx rr ready0", b1.req0_ready, 1);
        check_output("rst_tx rr ready1", b1.req1_ready, 0);
        tick();
        b1.req0_valid = 1'b0;
        b1.req1_valid = 1'b0;
        check_output("rst_tx rr di", b1.csr_di, 32'h10);
        tick();
        tick();
        tick();
        check_output("rst_tx stale irq ignored", b1.busy, 1);
        b1.tx_irq = 1'b1;
        tick();
        b1.tx_irq = 1'b0;
        check_output("rst_tx done", b1.busy, 0);

        // Timeout on the short-timeout instance, then the other requester wins.
        @(negedge sys_clk);
        b2.req0_valid = 1'b1;
        b2.req1_valid = 1'b1;
        b2.req0_data  = 8'h81;
        b2.req1_data  = 8'h82;
        #1;
        check_output("to ready0", b2.req0_ready, 1);
        tick();
        check_output("to csr_we", b2.csr_we, 1);
        check_output("to csr_a", b2.csr_a, 14'h2800);
        check_output("to csr_di", b2.csr_di, 32'h81);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n = k;
            if (b2.tx_timeout) break;
        end
        check_output("to latency", n, 12);
        check_output("to idle", b2.busy, 0);
        check_output("to next ready1", b2.req1_ready, 1);
        check_output("to next ready0", b2.req0_ready, 0);
        tick();
        b2.req0_valid = 1'b0;
        b2.req1_valid = 1'b0;
        check_output("to pulse end", b2.tx_timeout, 0);
        check_output("to next di", b2.csr_di, 32'h82);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
